// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------
// pipe_pkg : shared state encoding and mode constants for pipe_stage_skid
// Revision : 1.0
// ---------------------------------------------------------------------
`default_nettype none

package pipe_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_BOTH  = 2'd2
  } state_t;

  localparam int SKID_OFF = 0;
  localparam int SKID_ON  = 1;
endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------
// sat_counter : up-counter that sticks at all-ones, async active-high clear
// Revision    : 1.0
// ---------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != C_MAX)) begin
      cnt <= cnt + C_ONE;
    end
  end
endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------
// pipe_stage_skid : parametrised valid/ready pipeline register with flush,
//                   optional 2-entry skid buffer and saturating stall count
// Revision        : 1.0
// ---------------------------------------------------------------------
`default_nettype none

module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 2,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              rdy_reg;
  logic              accept, take;
  logic              load_in, load_skid, load_from_skid;

  assign out_valid_o = (state != ST_EMPTY);
  assign out_data_o  = main_data;
  assign out_ctrl_o  = main_ctrl;
  assign accept      = in_valid_i & in_ready_o;
  assign take        = out_valid_o & out_ready_i;

  // rdy_reg is the full registered ready with a skid, else a post-reset enable
  generate
    if (SKID == SKID_ON) begin : g_skid
      assign in_ready_o = rdy_reg;
    end else begin : g_noskid
      assign in_ready_o = rdy_reg & (out_ready_i | ~out_valid_o);
    end
  endgenerate

  always_comb begin
    state_nxt      = state;
    load_in        = 1'b0;
    load_skid      = 1'b0;
    load_from_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_FULL;
          load_in   = 1'b1;
        end
      end
      ST_FULL: begin
        if (accept && take) begin
          load_in = 1'b1;
        end else if (accept) begin
          state_nxt = ST_BOTH;
          load_skid = 1'b1;
        end else if (take) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_BOTH: begin
        if (take) begin
          state_nxt      = ST_FULL;
          load_from_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_nxt      = ST_EMPTY;
      load_in        = 1'b0;
      load_skid      = 1'b0;
      load_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_EMPTY;
      rdy_reg   <= 1'b0;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state   <= state_nxt;
      rdy_reg <= (SKID == SKID_ON) ? (state_nxt != ST_BOTH) : 1'b1;
      if (load_in) begin
        main_data <= in_data_i;
      end else if (load_from_skid) begin
        main_data <= skid_data;
      end
      // Control is zeroed on any entry into EMPTY so bubbles carry no side effects
      if (state_nxt == ST_EMPTY) begin
        main_ctrl <= '0;
      end else if (load_in) begin
        main_ctrl <= in_ctrl_i;
      end else if (load_from_skid) begin
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data_i;
        skid_ctrl <= in_ctrl_i;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk_i),
    .clr (rst_i),
    .inc (out_valid_o & ~out_ready_i),
    .cnt (stall_cnt_o)
  );
endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------
// tb_pipe_stage_skid : queue-model checked bench, one SKID=1 and one SKID=0 stage
// Revision           : 1.0
// ---------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_skid;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Stage A: skid buffer, 4-bit stall counter
  logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [63:0] a_in_data = '0, a_out_data;
  logic [1:0]  a_in_ctrl = '0, a_out_ctrl;
  logic [3:0]  a_stall;
  // Stage B: no skid, combinational ready
  logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [15:0] b_in_data = '0, b_out_data;
  logic [1:0]  b_in_ctrl = '0, b_out_ctrl;
  logic [15:0] b_stall;

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(2), .SKID(1), .CNT_W(4)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data), .in_ctrl_i(a_in_ctrl),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .out_ctrl_o(a_out_ctrl), .stall_cnt_o(a_stall));

  pipe_stage_skid #(.DATA_W(16), .CTRL_W(2), .SKID(0), .CNT_W(16)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data), .in_ctrl_i(b_in_ctrl),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .out_ctrl_o(b_out_ctrl), .stall_cnt_o(b_stall));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each stage is a FIFO of at most two beats; index 0 = A, 1 = B
  int          mcount [2];
  logic [63:0] mq_data[2][2];
  logic [1:0]  mq_ctrl[2][2];
  bit          mready [2];
  bit          malive [2];
  int unsigned mstall [2];
  int unsigned mmax   [2] = '{15, 65535};

  task automatic mstep(input int d, input bit iv, input logic [63:0] id, input logic [1:0] ic,
                       input bit ordy, input bit fl);
    bit rdy, acc, tk;
    rdy = (d == 0) ? mready[0] : (malive[1] && (ordy || mcount[1] == 0));
    acc = iv && rdy;
    tk  = (mcount[d] > 0) && ordy;
    if (mcount[d] > 0 && !ordy && mstall[d] < mmax[d]) mstall[d]++;
    if (fl) begin
      mcount[d] = 0;
    end else begin
      if (tk) begin
        mq_data[d][0] = mq_data[d][1];
        mq_ctrl[d][0] = mq_ctrl[d][1];
        mcount[d]--;
      end
      if (acc) begin
        mq_data[d][mcount[d]] = id;
        mq_ctrl[d][mcount[d]] = ic;
        mcount[d]++;
      end
    end
    malive[d] = 1'b1;
    mready[d] = (mcount[d] < 2);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        mcount[d] = 0; mready[d] = 0; malive[d] = 0; mstall[d] = 0;
      end
    end else begin
      mstep(0, a_in_valid, a_in_data, a_in_ctrl, a_out_ready, a_flush);
      mstep(1, b_in_valid, {48'b0, b_in_data}, b_in_ctrl, b_out_ready, b_flush);
    end
  end

  always @(negedge clk) begin
    chk("a_in_ready",  a_in_ready,  mready[0]);
    chk("a_out_valid", a_out_valid, mcount[0] > 0);
    chk("a_out_ctrl",  a_out_ctrl,  (mcount[0] > 0) ? mq_ctrl[0][0] : 2'b00);
    if (mcount[0] > 0) chk("a_out_data", a_out_data, mq_data[0][0]);
    chk("a_stall",     a_stall,     mstall[0]);
    chk("b_in_ready",  b_in_ready,  malive[1] && (b_out_ready || mcount[1] == 0));
    chk("b_out_valid", b_out_valid, mcount[1] > 0);
    chk("b_out_ctrl",  b_out_ctrl,  (mcount[1] > 0) ? mq_ctrl[1][0] : 2'b00);
    if (mcount[1] > 0) chk("b_out_data", b_out_data, mq_data[1][0]);
    chk("b_stall",     b_stall,     mstall[1]);
  end

  logic [63:0] a_log[$];
  logic [15:0] b_log[$];
  always @(posedge clk) begin
    if (!rst && a_out_valid && a_out_ready) a_log.push_back(a_out_data);
    if (!rst && b_out_valid && b_out_ready) b_log.push_back(b_out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [63:0] d, input logic [1:0] c);
    bit acc;
    int n;
    n = 0;
    a_in_valid = 1'b1; a_in_data = d; a_in_ctrl = c;
    do begin
      @(posedge clk);
      acc = a_in_ready;
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_a_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int idx;
    #3;
    chk("rst_in_ready", a_in_ready, 1'b0);
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_out_ctrl", a_out_ctrl, 2'b00);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("rel_in_ready_low", a_in_ready, 1'b0);
    tick();
    chk("rel_in_ready_high", a_in_ready, 1'b1);

    // Full-rate stream of 8 beats
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send_a(i, 2'b11);
    a_in_valid = 1'b0;
    tick(); tick();
    chk("stream_count", a_log.size(), 8);
    for (int i = 0; i < 8 && i < a_log.size(); i++) chk("stream_data", a_log[i], i + 1);
    chk("stream_stall", a_stall, 0);

    // Backpressure fills the skid
    a_out_ready = 1'b0;
    send_a(64'hA, 2'b01);
    a_in_data = 64'hB; a_in_ctrl = 2'b10;
    tick();
    a_in_valid = 1'b0;
    chk("both_in_ready", a_in_ready, 1'b0);
    chk("both_head", a_out_data, 64'hA);
    tick(); tick();
    chk("stall3", a_stall, 3);
    a_out_ready = 1'b1;
    tick(); tick();
    chk("ab_count", a_log.size(), 10);
    if (a_log.size() >= 10) begin
      chk("ab_first", a_log[8], 64'hA);
      chk("ab_second", a_log[9], 64'hB);
    end

    // Flush in BOTH with simultaneous offer and take
    a_out_ready = 1'b0;
    send_a(64'hD, 2'b10);
    a_in_data = 64'hE; a_in_ctrl = 2'b01;
    tick();
    a_in_data = 64'hC; a_in_ctrl = 2'b11; a_flush = 1'b1; a_out_ready = 1'b1;
    #1 chk("flush_both_ready", a_in_ready, 1'b0);
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("flush_valid", a_out_valid, 1'b0);
    chk("flush_ctrl", a_out_ctrl, 2'b00);
    tick(); tick();
    chk("flush_count", a_log.size(), 11);
    if (a_log.size() >= 11) chk("flush_take", a_log[10], 64'hD);

    // Flush overrides accept in FULL
    a_out_ready = 1'b0;
    send_a(64'hF, 2'b01);
    a_in_data = 64'h7; a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("flush_acc_valid", a_out_valid, 1'b0);
    tick();

    // Saturation of the 4-bit counter
    send_a(64'h5A, 2'b11);
    a_in_valid = 1'b0;
    repeat (20) tick();
    chk("sat15", a_stall, 15);
    a_out_ready = 1'b1;
    tick(); tick();
    if (a_log.size() >= 1) chk("sat_drain", a_log[a_log.size()-1], 64'h5A);

    // SKID=0: toggling downstream ready under continuous input
    idx = 0;
    b_in_valid = 1'b1; b_in_data = 16'h11; b_in_ctrl = 2'b01;
    for (int cyc = 0; cyc < 24 && b_in_valid; cyc++) begin
      b_out_ready = (cyc % 2 == 0);
      #1 chk("b_comb_ready", b_in_ready, b_out_ready || mcount[1] == 0);
      @(posedge clk);
      acc = b_in_valid && b_in_ready;
      #1;
      if (acc) begin
        idx++;
        if (idx == 6) b_in_valid = 1'b0;
        else b_in_data = 16'h11 + 16'(idx);
      end
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    tick(); tick();
    chk("b_count", b_log.size(), 6);
    for (int i = 0; i < 6 && i < b_log.size(); i++) chk("b_order", b_log[i], 16'h11 + 16'(i));

    // Reset mid-operation with A in BOTH
    a_out_ready = 1'b0;
    send_a(64'h1, 2'b01);
    a_in_data = 64'h2;
    tick();
    a_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", a_out_valid, 1'b0);
    chk("mid_rst_stall", a_stall, 0);
    chk("mid_rst_ready", a_in_ready, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", a_in_ready, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic parametrised pipeline stage register; successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data payload and a control bundle, with a valid/ready handshake, flush (bubble insertion), optional 2-entry skid buffer, and a saturating stall counter.
- Each CPU pipeline boundary instantiates one stage and sets widths per stage.

Parameters:
- DATA_W, 64: width of the data payload (ALU result, read data, rd address packed by the instantiator).
- CTRL_W, 2: width of the control bundle (e.g. MemToReg, RegWrite). Forced to 0 on bubbles.
- SKID, 1: 1 selects a 2-entry skid buffer with registered in_ready_o; 0 selects a single register with combinational ready.
- CNT_W, 16: stall counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset. One clock; reset is asynchronous and active-high.
- flush_i  in  1  discard all held entries; synchronous.
- in_valid_i  in  1  upstream entry valid.
- in_ready_o  out  1  stage can accept an entry.
- in_data_i  in  DATA_W  upstream payload.
- in_ctrl_i  in  CTRL_W  upstream control.
- out_valid_o  out  1  downstream entry valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DATA_W  held payload.
- out_ctrl_o  out  CTRL_W  held control; all-zero whenever out_valid_o=0.
- stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating.

Behaviour:
- Reset (async, rst_i=1): out_valid_o=0, out_data_o=0, out_ctrl_o=0, stall_cnt_o=0, skid empty, in_ready_o=0. in_ready_o rises on the first clk_i edge after rst_i falls.
- Handshake rules:
  - accept = in_valid_i & in_ready_o; take = out_valid_o & out_ready_i.
  - Upstream must hold data stable while in_valid_i=1 and not accepted; downstream likewise.
- SKID=0:
  - in_ready_o = out_ready_i | ~out_valid_o (combinational, after reset release).
  - On accept, the main register loads on the next edge. Latency 1 cycle, full throughput.
- SKID=1: states EMPTY, FULL, BOTH (main+skid). in_ready_o is registered: 1 in EMPTY/FULL, 0 in BOTH.
  - EMPTY: accept -> FULL (main loads input).
  - FULL: accept & take -> FULL (main loads input); accept & ~take -> BOTH (skid loads input); ~accept & take -> EMPTY; else hold.
  - BOTH: take -> FULL (main loads skid); else hold. No accept is possible.
  - Latency 1 cycle; throughput 1/cycle; order is strictly FIFO.
- Bubble rule: whenever the stage enters or remains in EMPTY, out_ctrl_o is 0. out_data_o holds its last value (don't-care).
- flush_i: on the next edge, go to EMPTY in both modes and zero out_ctrl_o. Flush overrides a simultaneous accept (the input is dropped) and a simultaneous take (downstream still sees the beat this cycle). stall_cnt_o is unaffected.
- Stall counter: increments on each edge where out_valid_o=1 & out_ready_i=0. Saturates at 2^CNT_W-1 and holds there. Cleared only by reset.
- Reset asserted mid-operation: immediate async clear of every output; skid contents are lost.
- Simultaneous flush_i and rst_i: reset wins.

Decomposition:
- pipe_pkg holds the state enum (ST_EMPTY=2'd0, ST_FULL=2'd1, ST_BOTH=2'd2) and the SKID mode constants.
- One sub-module, sat_counter (CNT_W, inc, async active-high clear), implements the stall counter. The skid logic stays inline.

Test Plan:
- Reset release, SKID=1, no input -> out_valid_o=0, out_ctrl_o=0, in_ready_o=0 in reset cycle then 1 on first edge.
- Stream 8 beats data=0x1..0x8, ctrl=2'b11, out_ready_i=1 -> outputs appear 1 cycle later, one per cycle, in order, stall_cnt_o=0.
- Beat A accepted, out_ready_i=0 for 3 cycles while B offered -> state BOTH, in_ready_o=0, stall_cnt_o=3. Release -> A then B delivered, no loss or duplication.
- flush_i in BOTH with a simultaneous in_valid_i beat C -> next cycle out_valid_o=0, out_ctrl_o=0; C never emitted.
- CNT_W=4, hold out_valid_o=1 & out_ready_i=0 for 20 cycles -> stall_cnt_o saturates at 15.
- SKID=0, out_ready_i toggling 1,0,1,0 with continuous input -> in_ready_o tracks out_ready_i | ~out_valid_o combinationally; all beats delivered in order.
